// File: rtl/display_timing_cfg.sv
// Runtime-reconfigurable display timing generator (clk_pix domain).
// Ports: clk_pix/rst; cfg_valid/cfg_ready handshake with cfg_{h,v}_{res,fp,sp,bp,pol};
//        cfg_err/cfg_applied status pulses; hsync, vsync, de, frame, line, sx, sy (registered).
module display_timing_cfg #(
    parameter int   CORDW = 12,
    parameter int   H_RES = 800,
    parameter int   H_FP  = 56,
    parameter int   H_SP  = 120,
    parameter int   H_BP  = 64,
    parameter logic H_POL = 1'b1,
    parameter int   V_RES = 600,
    parameter int   V_FP  = 37,
    parameter int   V_SP  = 6,
    parameter int   V_BP  = 23,
    parameter logic V_POL = 1'b1
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CORDW-2:0]        cfg_h_res,
    input  logic [CORDW-2:0]        cfg_h_fp,
    input  logic [CORDW-2:0]        cfg_h_sp,
    input  logic [CORDW-2:0]        cfg_h_bp,
    input  logic [CORDW-2:0]        cfg_v_res,
    input  logic [CORDW-2:0]        cfg_v_fp,
    input  logic [CORDW-2:0]        cfg_v_sp,
    input  logic [CORDW-2:0]        cfg_v_bp,
    input  logic                    cfg_h_pol,
    input  logic                    cfg_v_pol,
    output logic                    cfg_err,
    output logic                    cfg_applied,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy
);

    localparam int FW = CORDW - 1;
    localparam int SW = CORDW + 1;
    localparam logic [SW-1:0] BLANK_MAX = SW'(2 ** (CORDW - 1));

    localparam logic [FW-1:0] D_H_RES = FW'(H_RES);
    localparam logic [FW-1:0] D_H_FP  = FW'(H_FP);
    localparam logic [FW-1:0] D_H_SP  = FW'(H_SP);
    localparam logic [FW-1:0] D_H_BP  = FW'(H_BP);
    localparam logic [FW-1:0] D_V_RES = FW'(V_RES);
    localparam logic [FW-1:0] D_V_FP  = FW'(V_FP);
    localparam logic [FW-1:0] D_V_SP  = FW'(V_SP);
    localparam logic [FW-1:0] D_V_BP  = FW'(V_BP);
    localparam logic signed [CORDW-1:0] D_H_STA = CORDW'(-(H_FP + H_SP + H_BP));
    localparam logic signed [CORDW-1:0] D_V_STA = CORDW'(-(V_FP + V_SP + V_BP));

    // Blanking start; only validated timings (sum <= 2^(CORDW-1)) ever
    // reach this, so the CORDW-bit sum cannot overflow.
    function automatic logic [CORDW-1:0] f_sta(
        input logic [FW-1:0] fp,
        input logic [FW-1:0] sp,
        input logic [FW-1:0] bp
    );
        return CORDW'(0) - ({1'b0, fp} + {1'b0, sp} + {1'b0, bp});
    endfunction

    // Active mode
    logic [FW-1:0] r_h_res, r_h_fp, r_h_sp, r_h_bp;
    logic [FW-1:0] r_v_res, r_v_fp, r_v_sp, r_v_bp;
    logic          r_h_pol, r_v_pol;
    // Pending mode
    logic [FW-1:0] r_p_h_res, r_p_h_fp, r_p_h_sp, r_p_h_bp;
    logic [FW-1:0] r_p_v_res, r_p_v_fp, r_p_v_sp, r_p_v_bp;
    logic          r_p_h_pol, r_p_v_pol;
    logic          r_pend;
    logic          r_new;

    logic signed [CORDW-1:0] r_x, r_y;

    logic signed [CORDW-1:0] w_h_sta, w_hs_sta, w_hs_end;
    logic signed [CORDW-1:0] w_v_sta, w_vs_sta, w_vs_end;
    logic signed [CORDW-1:0] w_ph_sta, w_pv_sta;
    logic [CORDW-1:0]        w_h_last, w_v_last;
    logic                    w_x_last, w_y_last;
    logic                    w_h_raw, w_v_raw;
    logic [SW-1:0]           w_cfg_hsum, w_cfg_vsum;
    logic                    w_cfg_ok, w_take;

    assign w_h_sta  = f_sta(r_h_fp, r_h_sp, r_h_bp);
    assign w_hs_sta = w_h_sta + $signed({1'b0, r_h_fp});
    assign w_hs_end = w_hs_sta + $signed({1'b0, r_h_sp});
    assign w_v_sta  = f_sta(r_v_fp, r_v_sp, r_v_bp);
    assign w_vs_sta = w_v_sta + $signed({1'b0, r_v_fp});
    assign w_vs_end = w_vs_sta + $signed({1'b0, r_v_sp});
    assign w_ph_sta = f_sta(r_p_h_fp, r_p_h_sp, r_p_h_bp);
    assign w_pv_sta = f_sta(r_p_v_fp, r_p_v_sp, r_p_v_bp);

    assign w_h_last = {1'b0, r_h_res} - CORDW'(1);
    assign w_v_last = {1'b0, r_v_res} - CORDW'(1);
    assign w_x_last = (r_x == w_h_last);
    assign w_y_last = (r_y == w_v_last);

    assign w_h_raw = (r_x >= w_hs_sta) && (r_x < w_hs_end);
    assign w_v_raw = (r_y >= w_vs_sta) && (r_y < w_vs_end);

    // res fields are FW bits wide, so res <= 2^(CORDW-1)-1 always holds.
    assign w_cfg_hsum = {2'b00, cfg_h_fp} + {2'b00, cfg_h_sp} + {2'b00, cfg_h_bp};
    assign w_cfg_vsum = {2'b00, cfg_v_fp} + {2'b00, cfg_v_sp} + {2'b00, cfg_v_bp};
    assign w_cfg_ok   = (cfg_h_res != '0) && (cfg_v_res != '0)
                     && (cfg_h_sp != '0) && (cfg_v_sp != '0)
                     && (w_cfg_hsum <= BLANK_MAX) && (w_cfg_vsum <= BLANK_MAX);

    assign cfg_ready = ~r_pend;
    assign w_take    = cfg_valid & ~r_pend;

    // Counters, mode registers and the pending slot
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_h_res   <= D_H_RES;
            r_h_fp    <= D_H_FP;
            r_h_sp    <= D_H_SP;
            r_h_bp    <= D_H_BP;
            r_h_pol   <= H_POL;
            r_v_res   <= D_V_RES;
            r_v_fp    <= D_V_FP;
            r_v_sp    <= D_V_SP;
            r_v_bp    <= D_V_BP;
            r_v_pol   <= V_POL;
            r_p_h_res <= '0;
            r_p_h_fp  <= '0;
            r_p_h_sp  <= '0;
            r_p_h_bp  <= '0;
            r_p_h_pol <= 1'b0;
            r_p_v_res <= '0;
            r_p_v_fp  <= '0;
            r_p_v_sp  <= '0;
            r_p_v_bp  <= '0;
            r_p_v_pol <= 1'b0;
            r_pend    <= 1'b0;
            r_new     <= 1'b0;
            r_x       <= D_H_STA;
            r_y       <= D_V_STA;
        end else begin
            r_new <= 1'b0;
            if (w_x_last) begin
                if (w_y_last) begin
                    if (r_pend) begin
                        // Frame boundary: swap in the pending mode and
                        // restart from its own blanking origin.
                        r_h_res <= r_p_h_res;
                        r_h_fp  <= r_p_h_fp;
                        r_h_sp  <= r_p_h_sp;
                        r_h_bp  <= r_p_h_bp;
                        r_h_pol <= r_p_h_pol;
                        r_v_res <= r_p_v_res;
                        r_v_fp  <= r_p_v_fp;
                        r_v_sp  <= r_p_v_sp;
                        r_v_bp  <= r_p_v_bp;
                        r_v_pol <= r_p_v_pol;
                        r_x     <= w_ph_sta;
                        r_y     <= w_pv_sta;
                        r_pend  <= 1'b0;
                        r_new   <= 1'b1;
                    end else begin
                        r_x <= w_h_sta;
                        r_y <= w_v_sta;
                    end
                end else begin
                    r_x <= w_h_sta;
                    r_y <= r_y + CORDW'(1);
                end
            end else begin
                r_x <= r_x + CORDW'(1);
            end
            // Accepting implies no pending mode, so never collides with apply.
            if (w_take && w_cfg_ok) begin
                r_p_h_res <= cfg_h_res;
                r_p_h_fp  <= cfg_h_fp;
                r_p_h_sp  <= cfg_h_sp;
                r_p_h_bp  <= cfg_h_bp;
                r_p_h_pol <= cfg_h_pol;
                r_p_v_res <= cfg_v_res;
                r_p_v_fp  <= cfg_v_fp;
                r_p_v_sp  <= cfg_v_sp;
                r_p_v_bp  <= cfg_v_bp;
                r_p_v_pol <= cfg_v_pol;
                r_pend    <= 1'b1;
            end
        end
    end

    // Registered outputs, one cycle behind x/y
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sx          <= D_H_STA;
            sy          <= D_V_STA;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            frame       <= 1'b0;
            line        <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_applied <= 1'b0;
        end else begin
            sx          <= r_x;
            sy          <= r_y;
            hsync       <= w_h_raw ^ ~r_h_pol;
            vsync       <= w_v_raw ^ ~r_v_pol;
            de          <= ~r_x[CORDW-1] & ~r_y[CORDW-1];
            frame       <= (r_x == w_h_sta) && (r_y == w_v_sta);
            line        <= (r_x == w_h_sta);
            cfg_err     <= w_take & ~w_cfg_ok;
            // r_new is high exactly while x/y sit at the new origin.
            cfg_applied <= r_new;
        end
    end

endmodule

// File: tb/tb_display_timing_cfg.sv
// Testbench for display_timing_cfg: frame-position reference model checked
// every cycle, plus literal checks on a default-parameter instance.
module tb_display_timing_cfg;

    localparam int DH_RES = 20;
    localparam int DH_FP  = 3;
    localparam int DH_SP  = 5;
    localparam int DH_BP  = 4;
    localparam int DV_RES = 10;
    localparam int DV_FP  = 2;
    localparam int DV_SP  = 2;
    localparam int DV_BP  = 3;

    typedef struct {
        int hres, hfp, hsp, hbp;
        int vres, vfp, vsp, vbp;
        bit hpol, vpol;
    } mode_t;

    logic clk_pix = 1'b0;
    logic rst = 1'b1;
    always #5 clk_pix = ~clk_pix;

    logic        cfg_valid = 1'b0;
    logic        d2_valid = 1'b0;
    logic [10:0] cfg_h_res = '0, cfg_h_fp = '0, cfg_h_sp = '0, cfg_h_bp = '0;
    logic [10:0] cfg_v_res = '0, cfg_v_fp = '0, cfg_v_sp = '0, cfg_v_bp = '0;
    logic        cfg_h_pol = 1'b0, cfg_v_pol = 1'b0;

    logic cfg_ready, cfg_err, cfg_applied, hsync, vsync, de, frame, line;
    logic signed [11:0] sx, sy;
    logic d2_ready, d2_err, d2_applied, d2_hsync, d2_vsync, d2_de, d2_frame, d2_line;
    logic signed [11:0] d2_sx, d2_sy;

    int checks = 0;
    int errors = 0;

    display_timing_cfg #(
        .CORDW(12),
        .H_RES(DH_RES), .H_FP(DH_FP), .H_SP(DH_SP), .H_BP(DH_BP), .H_POL(1'b1),
        .V_RES(DV_RES), .V_FP(DV_FP), .V_SP(DV_SP), .V_BP(DV_BP), .V_POL(1'b1)
    ) dut (
        .clk_pix(clk_pix), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_res(cfg_h_res), .cfg_h_fp(cfg_h_fp),
        .cfg_h_sp(cfg_h_sp), .cfg_h_bp(cfg_h_bp),
        .cfg_v_res(cfg_v_res), .cfg_v_fp(cfg_v_fp),
        .cfg_v_sp(cfg_v_sp), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
        .cfg_err(cfg_err), .cfg_applied(cfg_applied),
        .hsync(hsync), .vsync(vsync), .de(de),
        .frame(frame), .line(line), .sx(sx), .sy(sy)
    );

    display_timing_cfg dut2 (
        .clk_pix(clk_pix), .rst(rst),
        .cfg_valid(d2_valid), .cfg_ready(d2_ready),
        .cfg_h_res(cfg_h_res), .cfg_h_fp(cfg_h_fp),
        .cfg_h_sp(cfg_h_sp), .cfg_h_bp(cfg_h_bp),
        .cfg_v_res(cfg_v_res), .cfg_v_fp(cfg_v_fp),
        .cfg_v_sp(cfg_v_sp), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
        .cfg_err(d2_err), .cfg_applied(d2_applied),
        .hsync(d2_hsync), .vsync(d2_vsync), .de(d2_de),
        .frame(d2_frame), .line(d2_line), .sx(d2_sx), .sy(d2_sy)
    );

    function automatic mode_t def_mode();
        mode_t m;
        m.hres = DH_RES; m.hfp = DH_FP; m.hsp = DH_SP; m.hbp = DH_BP;
        m.vres = DV_RES; m.vfp = DV_FP; m.vsp = DV_SP; m.vbp = DV_BP;
        m.hpol = 1'b1;   m.vpol = 1'b1;
        return m;
    endfunction

    function automatic mode_t mk(input int hr, hf, hs, hb, vr, vf, vs, vb,
                                 input bit hp, vp);
        mode_t m;
        m.hres = hr; m.hfp = hf; m.hsp = hs; m.hbp = hb;
        m.vres = vr; m.vfp = vf; m.vsp = vs; m.vbp = vb;
        m.hpol = hp; m.vpol = vp;
        return m;
    endfunction

    function automatic bit legal(input mode_t m);
        return m.hres != 0 && m.vres != 0 && m.hsp != 0 && m.vsp != 0
            && (m.hfp + m.hsp + m.hbp) <= 2048
            && (m.vfp + m.vsp + m.vbp) <= 2048
            && m.hres <= 2047 && m.vres <= 2047;
    endfunction

    // Reference model: outputs follow from the position within the frame.
    mode_t m_cur, m_pend, m_in;
    int    m_pos;
    bit    m_has_pend, m_new;
    int    e_sx, e_sy;
    bit    e_hs, e_vs, e_de, e_fr, e_ln, e_ap, e_er, e_rdy;

    always @(posedge clk_pix) begin : model
        int L, F, hx, vy, hb, vb;
        bit was, hraw, vraw;
        if (rst) begin
            m_cur = def_mode();
            m_pos = 0;
            m_has_pend = 0;
            m_new = 0;
            e_sx = -(DH_FP + DH_SP + DH_BP);
            e_sy = -(DV_FP + DV_SP + DV_BP);
            e_hs = 0; e_vs = 0; e_de = 0; e_fr = 0; e_ln = 0;
            e_ap = 0; e_er = 0; e_rdy = 1;
        end else begin
            L  = m_cur.hres + m_cur.hfp + m_cur.hsp + m_cur.hbp;
            F  = m_cur.vres + m_cur.vfp + m_cur.vsp + m_cur.vbp;
            hb = m_cur.hfp + m_cur.hsp + m_cur.hbp;
            vb = m_cur.vfp + m_cur.vsp + m_cur.vbp;
            hx = m_pos % L;
            vy = m_pos / L;
            hraw = hx >= m_cur.hfp && hx < m_cur.hfp + m_cur.hsp;
            vraw = vy >= m_cur.vfp && vy < m_cur.vfp + m_cur.vsp;
            e_sx = hx - hb;
            e_sy = vy - vb;
            e_hs = hraw ^ !m_cur.hpol;
            e_vs = vraw ^ !m_cur.vpol;
            e_de = hx >= hb && vy >= vb;
            e_fr = m_pos == 0;
            e_ln = hx == 0;
            e_ap = m_new;
            e_er = 0;
            m_new = 0;
            was = m_has_pend;
            if (m_pos == L * F - 1) begin
                m_pos = 0;
                if (m_has_pend) begin
                    m_cur = m_pend;
                    m_has_pend = 0;
                    m_new = 1;
                end
            end else begin
                m_pos++;
            end
            m_in = mk(int'(cfg_h_res), int'(cfg_h_fp), int'(cfg_h_sp),
                      int'(cfg_h_bp), int'(cfg_v_res), int'(cfg_v_fp),
                      int'(cfg_v_sp), int'(cfg_v_bp), cfg_h_pol, cfg_v_pol);
            if (cfg_valid && !was) begin
                if (legal(m_in)) begin
                    m_pend = m_in;
                    m_has_pend = 1;
                end else begin
                    e_er = 1;
                end
            end
            e_rdy = !m_has_pend;
        end
    end

    int cyc = 0;
    always @(negedge clk_pix) begin : compare
        bit bad;
        cyc++;
        checks++;
        bad = (int'(sx) !== e_sx) || (int'(sy) !== e_sy)
           || (hsync !== e_hs) || (vsync !== e_vs) || (de !== e_de)
           || (frame !== e_fr) || (line !== e_ln)
           || (cfg_applied !== e_ap) || (cfg_err !== e_er)
           || (cfg_ready !== e_rdy);
        if (bad) begin
            errors++;
            $display("FAIL model cyc %0d got/exp: sx %0d/%0d sy %0d/%0d hs %b/%b vs %b/%b de %b/%b fr %b/%b ln %b/%b ap %b/%b er %b/%b rdy %b/%b",
                     cyc, sx, e_sx, sy, e_sy, hsync, e_hs, vsync, e_vs,
                     de, e_de, frame, e_fr, line, e_ln, cfg_applied, e_ap,
                     cfg_err, e_er, cfg_ready, e_rdy);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic offer(input mode_t m);
        cfg_h_res = 11'(m.hres); cfg_h_fp = 11'(m.hfp);
        cfg_h_sp  = 11'(m.hsp);  cfg_h_bp = 11'(m.hbp);
        cfg_v_res = 11'(m.vres); cfg_v_fp = 11'(m.vfp);
        cfg_v_sp  = 11'(m.vsp);  cfg_v_bp = 11'(m.vbp);
        cfg_h_pol = m.hpol;      cfg_v_pol = m.vpol;
        cfg_valid = 1'b1;
        @(negedge clk_pix);
        cfg_valid = 1'b0;
    endtask

    // which: 0 = cfg_applied, 1 = frame, 2 = line without frame
    task automatic wait_sig(input int which, input int lim, input string nm,
                            output int k);
        k = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk_pix);
            if ((which == 0 && cfg_applied) || (which == 1 && frame)
                || (which == 2 && line && !frame)) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: got none within %0d cycles", nm, lim);
        end
    endtask

    initial begin : stim
        int k, l1, l2, hs1, hscnt, napp, fr1, fr2;
        mode_t a, b, c;

        a = mk(8, 1, 3, 2, 6, 1, 1, 2, 1'b0, 1'b0);
        b = mk(1, 0, 1, 0, 1, 0, 1, 0, 1'b1, 1'b1);
        c = mk(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0);

        repeat (3) @(negedge clk_pix);
        chk("rst sx", int'(sx), -12);
        chk("rst sy", int'(sy), -7);
        chk("rst hsync", int'(hsync), 0);
        chk("rst ready", int'(cfg_ready), 1);
        chk("rst frame", int'(frame), 0);
        chk("d2 rst sx", int'(d2_sx), -240);
        chk("d2 rst sy", int'(d2_sy), -66);
        chk("d2 rst vsync", int'(d2_vsync), 0);
        #2 rst = 1'b0;

        l1 = 0; l2 = 0; hs1 = 0; hscnt = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk_pix);
            if (i == 1) begin
                chk("first frame", int'(frame), 1);
                chk("first sx", int'(sx), -12);
                chk("first line", int'(line), 1);
                chk("d2 first frame", int'(d2_frame), 1);
            end
            if (d2_line) begin
                if (l1 == 0) l1 = i;
                else if (l2 == 0) l2 = i;
            end
            if (d2_hsync && hs1 == 0) hs1 = i;
            if (i <= 1040 && d2_hsync) hscnt++;
        end
        chk("d2 line1", l1, 1);
        chk("d2 line period", l2 - l1, 1040);
        chk("d2 hsync start", hs1 - l1, 56);
        chk("d2 hsync width", hscnt, 120);

        offer(a);
        chk("A pending ready", int'(cfg_ready), 0);
        offer(b);
        chk("busy ready", int'(cfg_ready), 0);
        chk("busy no err", int'(cfg_err), 0);
        wait_sig(0, 1200, "A applied", k);
        chk("A frame", int'(frame), 1);
        chk("A sx", int'(sx), -6);
        chk("A sy", int'(sy), -4);
        chk("A hsync idle", int'(hsync), 1);
        wait_sig(1, 200, "A period", k);
        chk("A frame period", k, 140);

        offer(b);
        chk("B pending ready", int'(cfg_ready), 0);
        wait_sig(0, 300, "B applied", k);
        chk("B sx", int'(sx), -1);
        chk("B line", int'(line), 1);
        chk("B hsync", int'(hsync), 1);
        wait_sig(1, 10, "B period", k);
        chk("B frame period", k, 4);
        chk("B frame line", int'(line), 1);

        a.hsp = 0;
        offer(a);
        chk("err hsp0", int'(cfg_err), 1);
        chk("err ready", int'(cfg_ready), 1);
        a.hsp = 3;
        a.vres = 0;
        offer(a);
        chk("err vres0", int'(cfg_err), 1);
        a.vres = 6;
        offer(mk(8, 2047, 1, 1, 6, 1, 1, 2, 1'b0, 1'b0));
        chk("err hsum2049", int'(cfg_err), 1);
        offer(mk(8, 1, 3, 2, 6, 2046, 1, 2, 1'b0, 1'b0));
        chk("err vsum2049", int'(cfg_err), 1);
        chk("err keep ready", int'(cfg_ready), 1);

        // Offer lands on the counter wrap cycle: applies one frame later.
        wait_sig(2, 8, "wrap phase", k);
        cfg_h_res = 11'(c.hres); cfg_h_fp = 11'(c.hfp);
        cfg_h_sp  = 11'(c.hsp);  cfg_h_bp = 11'(c.hbp);
        cfg_v_res = 11'(c.vres); cfg_v_fp = 11'(c.vfp);
        cfg_v_sp  = 11'(c.vsp);  cfg_v_bp = 11'(c.vbp);
        cfg_h_pol = c.hpol;      cfg_v_pol = c.vpol;
        cfg_valid = 1'b1;
        @(negedge clk_pix);
        cfg_valid = 1'b0;
        if (cfg_applied) k = 0;
        else wait_sig(0, 20, "C applied", k);
        chk("C apply delay", k + 1, 6);

        repeat (5) @(negedge clk_pix);
        offer(mk(8, 1, 3, 2, 6, 1, 1, 2, 1'b0, 1'b0));
        chk("D pending ready", int'(cfg_ready), 0);
        repeat (10) @(negedge clk_pix);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk_pix);
        chk("rst2 sx", int'(sx), -12);
        chk("rst2 sy", int'(sy), -7);
        chk("rst2 ready", int'(cfg_ready), 1);
        chk("rst2 de", int'(de), 0);
        #2 rst = 1'b0;

        napp = 0; fr1 = 0; fr2 = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk_pix);
            if (cfg_applied) napp++;
            if (frame) begin
                if (fr1 == 0) fr1 = i;
                else if (fr2 == 0) fr2 = i;
            end
        end
        chk("rst2 no applied", napp, 0);
        chk("rst2 frame1", fr1, 1);
        chk("rst2 frame period", fr2 - fr1, 544);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
